instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/instr_fetch_mem.sv | 29 ++
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and instruction field widths,
// used by the fetch unit and by the downstream execute stage.
package cpu_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 16;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Field extraction helpers for the classic 6/5/5/16 instruction layout.
  function automatic logic [OPCODE_W-1:0] opcode_of(input instr_t instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

  function automatic logic [IMM_W-1:0] imm_of(input instr_t instr);
    return instr[IMM_W-1:0];
  endfunction

endpackage

// File: rtl/instr_fetch_mem.sv
// Instruction store: DEPTH x 32-bit register array with a synchronous write
// port and a combinational read port.
module instr_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  instr_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output instr_t        rd_data
);

  instr_t mem [DEPTH];

  // Write the addressed word when enabled.
  // NOTE: the array has no reset; a program loaded once survives any number of resets.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds a small loaded program and issues it one word
// at a time over a valid/ready handshake to the execute stage.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_pc,
  output logic          done
);

  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LEN_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PC_ONE    = AW'(1);

  fetch_state_t  state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic          valid_d, done_d;
  instr_t        instr_d;
  logic [AW-1:0] pc_d, pc_inc, rd_addr;
  instr_t        rd_data;
  logic          mem_we, start_ok, last_word;

  // Loads only while no program is being issued and no start is competing.
  assign mem_we    = ld_en && !start && (state_q != RUN);
  assign start_ok  = start && (prog_len != '0) && (prog_len <= LEN_DEPTH);
  assign pc_inc    = out_pc + PC_ONE;
  assign last_word = ({1'b0, out_pc} == (len_q - LEN_ONE));
  // Word 0 is presented on start; afterwards the read port looks one ahead.
  assign rd_addr   = (state_q == RUN) ? pc_inc : '0;

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next-state and next-output decode.
  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    valid_d = out_valid;
    instr_d = out_instr;
    pc_d    = out_pc;
    done_d  = done;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          len_d   = prog_len;
          pc_d    = '0;
          instr_d = rd_data;
          valid_d = 1'b1;
          done_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          valid_d = 1'b0;
          done_d  = 1'b0;
          state_d = IDLE;
        end else if (out_valid && out_ready) begin
          if (last_word) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            pc_d    = pc_inc;
            instr_d = rd_data;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      out_valid <= valid_d;
      out_instr <= instr_d;
      out_pc    <= pc_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected (pc, instr) pairs are queued when
// a run is started and compared as the DUT hands each word downstream.
module tb_instr_fetch;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   instr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, ld_en, start, flush, out_ready;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [AW:0]   prog_len;
  logic          out_valid, done;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;

  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;
  int          pc2_cnt = 0;
  exp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];

  instr_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .prog_len  (prog_len),
    .start     (start),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: counts valid cycles and retires accepted words against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid) begin
      valid_cnt++;
      if (out_pc == AW'(2)) pc2_cnt++;
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_extra_word", 64'(out_pc), 64'hFFFF);
        end else begin
          e = sb_q.pop_front();
          check("sb_pc", 64'(out_pc), 64'(e.pc));
          check("sb_instr", 64'(out_instr), 64'(e.instr));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = AW'(addr);
    ld_data = data;
    tick();
    ld_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic push_prog(input int len);
    for (int i = 0; i < len; i++) sb_q.push_back('{pc: AW'(i), instr: model_mem[i]});
  endtask

  task automatic start_run(input int len);
    push_prog(len);
    prog_len  = (AW+1)'(len);
    valid_cnt = 0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("start_valid", 64'(out_valid), 64'd1);
    check("start_pc", 64'(out_pc), 64'd0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_reached", 64'(done), 64'd1);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic wait_pc(input int p, input int budget);
    int n = 0;
    while (out_pc != AW'(p) && n < budget) begin
      tick();
      n++;
    end
    check("reach_pc", 64'(out_pc), 64'(p));
  endtask

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; start = 1'b0; flush = 1'b0; out_ready = 1'b0;
    ld_addr = '0; ld_data = '0; prog_len = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;
    repeat (3) tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    load(0, 32'h2401002D); load(1, 32'h2402FFEC); load(2, 32'h2403FFC4);
    load(3, 32'h2404001E); load(4, 32'h00222821); load(5, 32'h00642821);
    load(6, 32'h00A62823);

    // Straight run, downstream always ready.
    out_ready = 1'b1;
    start_run(7);
    wait_done(50);
    check("run7_valid_cycles", 64'(valid_cnt), 64'd7);
    check("run7_valid_off", 64'(out_valid), 64'd0);
    check("run7_pc_last", 64'(out_pc), 64'd6);

    // Back-pressure for three cycles on pc 2.
    pc2_cnt = 0;
    start_run(7);
    wait_pc(2, 20);
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    wait_done(50);
    check("stall_pc2_cycles", 64'(pc2_cnt), 64'd4);
    check("stall_valid_cycles", 64'(valid_cnt), 64'd10);

    // Flush mid-run on pc 4, then restart from 0.
    start_run(7);
    wait_pc(4, 20);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_left", 64'(sb_q.size()), 64'd3);
    sb_q.delete();
    repeat (2) tick();
    check("flush_idle_valid", 64'(out_valid), 64'd0);
    check("flush_idle_done", 64'(done), 64'd0);
    out_ready = 1'b1;
    start_run(7);
    wait_done(50);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_done", 64'(done), 64'd1);

    // Full-depth program: last issue at pc 7 with no wrap.
    load(7, 32'h08000000);
    start_run(8);
    wait_done(50);
    repeat (2) tick();
    check("full_pc_hold", 64'(out_pc), 64'd7);
    check("full_valid_off", 64'(out_valid), 64'd0);
    check("full_valid_cycles", 64'(valid_cnt), 64'd8);

    // Illegal lengths are ignored.
    prog_len = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("len0_valid", 64'(out_valid), 64'd0);
    check("len0_done", 64'(done), 64'd1);
    prog_len = (AW+1)'(9);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("len9_valid", 64'(out_valid), 64'd0);
    check("len9_done", 64'(done), 64'd1);

    // Reset mid-run on pc 3; memory must survive.
    start_run(7);
    wait_pc(3, 20);
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_pc", 64'(out_pc), 64'd0);
    check("midrst_instr", 64'(out_instr), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    sb_q.delete();
    tick();
    out_ready = 1'b1;
    start_run(4);
    wait_done(50);

    // Load attempt during RUN is ignored.
    out_ready = 1'b0;
    start_run(7);
    ld_en = 1'b1; ld_addr = '0; ld_data = 32'hDEADBEEF;
    tick();
    ld_en = 1'b0;
    out_ready = 1'b1;
    wait_done(50);

    // Load together with start is ignored; words 0 and 1 must be the originals.
    push_prog(7);
    prog_len = (AW+1)'(7);
    start = 1'b1; ld_en = 1'b1; ld_addr = AW'(1); ld_data = 32'hBAD0BAD0;
    tick();
    start = 1'b0; ld_en = 1'b0;
    check("ldstart_valid", 64'(out_valid), 64'd1);
    wait_done(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
